// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_pkg: shared geometry defaults, coordinate type and colour codes
// Rev 1.0
// ----------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int COORD_W          = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Colours packed as {r[1:0], g[1:0], b[1:0]}
  localparam logic [5:0] COL_BLACK  = 6'b00_00_00;
  localparam logic [5:0] COL_WHITE  = 6'b11_11_11;
  localparam logic [5:0] COL_RED    = 6'b11_00_00;
  localparam logic [5:0] COL_DKBLUE = 6'b00_00_01;

  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/vga_bounce_box_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_bounce_box_if: timing inputs and pixel/sync outputs of the box stage
// Rev 1.0
// ----------------------------------------------------------------------
interface vga_bounce_box_if;
  import vga_pkg::*;

  coord_t     h_count;
  coord_t     v_count;
  logic       display_en;
  logic       h_sync_in;
  logic       v_sync_in;
  logic       pause;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       h_sync;
  logic       v_sync;

  modport master (
    output h_count, v_count, display_en, h_sync_in, v_sync_in, pause,
    input  r, g, b, h_sync, v_sync
  );

  modport slave (
    input  h_count, v_count, display_en, h_sync_in, v_sync_in, pause,
    output r, g, b, h_sync, v_sync
  );

endinterface
`default_nettype wire

// File: rtl/vga_box_mover.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_box_mover: one-axis box position that steps and bounces in [0, LIM]
// Rev 1.0
// ----------------------------------------------------------------------
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int LIM  = 608,
  parameter int STEP = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   move,
  output coord_t pos
);

  localparam logic [COORD_W:0] c_lim  = (COORD_W+1)'(LIM);
  localparam logic [COORD_W:0] c_step = (COORD_W+1)'(STEP);

  coord_t           r_pos;
  dir_e             r_dir;
  logic [COORD_W:0] w_cur;
  logic [COORD_W:0] w_up;

  // One extra bit keeps the bounds tests free of wrap-around
  assign w_cur = {1'b0, r_pos};
  assign w_up  = w_cur + c_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos <= '0;
      r_dir <= DIR_INC;
    end else if (move) begin
      if (r_dir == DIR_INC) begin
        if (w_up >= c_lim) begin
          r_pos <= c_lim[COORD_W-1:0];
          r_dir <= DIR_DEC;
        end else begin
          r_pos <= w_up[COORD_W-1:0];
        end
      end else begin
        if (w_cur <= c_step) begin
          r_pos <= '0;
          r_dir <= DIR_INC;
        end else begin
          r_pos <= r_pos - c_step[COORD_W-1:0];
        end
      end
    end
  end

  assign pos = r_pos;

endmodule
`default_nettype wire

// File: rtl/vga_bounce_box.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_bounce_box: bouncing white square over red border and checkerboard
// Rev 1.0
// ----------------------------------------------------------------------
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  vga_bounce_box_if.slave  bus
);

  localparam coord_t           c_h_last = COORD_W'(H_ACTIVE - 1);
  localparam coord_t           c_v_last = COORD_W'(V_ACTIVE - 1);
  localparam coord_t           c_v_tick = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W:0] c_box    = (COORD_W+1)'(BOX_SIZE);

  logic             w_tick;
  logic             w_move;
  coord_t           w_box_x;
  coord_t           w_box_y;
  logic [COORD_W:0] w_h;
  logic [COORD_W:0] w_v;
  logic [COORD_W:0] w_bx;
  logic [COORD_W:0] w_by;
  logic             w_in_box;
  logic             w_border;
  logic [5:0]       w_col;
  logic [5:0]       r_rgb;
  logic             r_h_sync;
  logic             r_v_sync;

  // Tick lands in vertical blanking, so the box never moves mid-frame
  assign w_tick = (bus.h_count == '0) && (bus.v_count == c_v_tick);
  assign w_move = w_tick && !bus.pause;

  vga_box_mover #(
    .LIM  (H_ACTIVE - BOX_SIZE),
    .STEP (STEP)
  ) u_mover_x (
    .clk  (clk_in),
    .rst  (reset),
    .move (w_move),
    .pos  (w_box_x)
  );

  vga_box_mover #(
    .LIM  (V_ACTIVE - BOX_SIZE),
    .STEP (STEP)
  ) u_mover_y (
    .clk  (clk_in),
    .rst  (reset),
    .move (w_move),
    .pos  (w_box_y)
  );

  assign w_h  = {1'b0, bus.h_count};
  assign w_v  = {1'b0, bus.v_count};
  assign w_bx = {1'b0, w_box_x};
  assign w_by = {1'b0, w_box_y};

  assign w_in_box = (w_h >= w_bx) && (w_h < w_bx + c_box) &&
                    (w_v >= w_by) && (w_v < w_by + c_box);
  assign w_border = (bus.h_count == '0) || (bus.h_count == c_h_last) ||
                    (bus.v_count == '0) || (bus.v_count == c_v_last);

  always_comb begin
    w_col = COL_BLACK;
    if (!bus.display_en) begin
      w_col = COL_BLACK;
    end else if (w_in_box) begin
      w_col = COL_WHITE;
    end else if (w_border) begin
      w_col = COL_RED;
    end else if (bus.h_count[5] ^ bus.v_count[5]) begin
      w_col = COL_DKBLUE;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_rgb    <= COL_BLACK;
      r_h_sync <= 1'b1;
      r_v_sync <= 1'b1;
    end else begin
      r_rgb    <= w_col;
      r_h_sync <= bus.h_sync_in;
      r_v_sync <= bus.v_sync_in;
    end
  end

  assign bus.r      = r_rgb[5:4];
  assign bus.g      = r_rgb[3:2];
  assign bus.b      = r_rgb[1:0];
  assign bus.h_sync = r_h_sync;
  assign bus.v_sync = r_v_sync;

endmodule
`default_nettype wire
